// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, NOP encoding, reset PC and fetch FSM states.
// The fetch-halt state exists only when IFETCH_MISALIGN_CHECK_EN is defined.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef IFETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {StReq, StWait, StKill, StHalt} fetch_state_e;
`else
  typedef enum logic [1:0] {StReq, StWait, StKill} fetch_state_e;
`endif

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one instruction with its PC and fault flag.
// Priority is flush (optionally loading a fault entry), then load, then consume.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] ResetPc = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        fault_i,
  input  logic [31:0] fault_pc_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        consume_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= ResetPc;
      fault_q <= 1'b0;
    end else if (flush_i) begin
      // A faulting redirect replaces the flushed entry with a NOP marked as faulting
      valid_q <= fault_i;
      instr_q <= NOP_INSTR;
      fault_q <= fault_i;
      if (fault_i) begin
        pc_q <= fault_pc_i;
      end
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
      fault_q <= 1'b0;
    end else if (consume_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, IF/ID register.
// Define IFETCH_MISALIGN_CHECK_EN to fault and halt on misaligned redirect targets.
module ifetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned XLEN     = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            outstanding;
  logic            out_after;
  logic            misalign;
  logic            rsp_load;
  logic            consume;

`ifdef IFETCH_MISALIGN_CHECK_EN
  // Tracks a response still owed by memory while halted
  logic halt_pend_q;
  assign misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign outstanding = (state_q == StWait) || (state_q == StKill) ||
                       ((state_q == StHalt) && halt_pend_q);
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign misalign    = 1'b0;
  assign outstanding = (state_q == StWait) || (state_q == StKill);
`endif

  assign out_after = outstanding && !imem_rvalid;
  assign imem_req  = !rst && (state_q == StReq) && !redirect_valid && (!id_valid || id_ready);
  assign imem_addr = pc_q;
  assign rsp_load  = (state_q == StWait) && imem_rvalid && !redirect_valid;
  assign consume   = id_valid && id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
`ifdef IFETCH_MISALIGN_CHECK_EN
      halt_pend_q <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      // A response still in flight must be swallowed before fetching the target
      state_q <= out_after ? StKill : StReq;
`ifdef IFETCH_MISALIGN_CHECK_EN
      halt_pend_q <= out_after;
      if (misalign) begin
        state_q <= StHalt;
      end
`endif
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_req) begin
            state_q  <= StWait;
            req_pc_q <= pc_q;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            state_q <= StReq;
            pc_q    <= pc_q + {{(XLEN-3){1'b0}}, 3'd4};
          end
        end
        StKill: begin
          if (imem_rvalid) begin
            state_q <= StReq;
          end
        end
`ifdef IFETCH_MISALIGN_CHECK_EN
        StHalt: begin
          if (imem_rvalid) begin
            halt_pend_q <= 1'b0;
          end
        end
`endif
        default: state_q <= StReq;
      endcase
    end
  end

  if_id_reg #(
    .ResetPc(RESET_PC)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (redirect_valid),
    .fault_i   (misalign),
    .fault_pc_i(redirect_pc),
    .load_i    (rsp_load),
    .instr_i   (imem_rdata),
    .pc_i      (req_pc_q),
    .consume_i (consume),
    .valid_o   (id_valid),
    .instr_o   (id_instr),
    .pc_o      (id_pc),
    .fault_o   (id_fault)
  );

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the five-stage core, directly upstream of the decode stage. Owns the program counter, issues one word-aligned request at a time to instruction memory, and holds the returned instruction with its PC in the IF/ID pipeline register until decode accepts it. Supports backpressure from decode and PC redirect/flush from branch/jump resolution, including discard of an in-flight memory response.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- XLEN, 32: address/data width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  request strobe, valid for one cycle per fetch.
- imem_addr  out  32  fetch address; equals pc, bits [1:0] always 0.
- imem_rvalid  in  1  response valid, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- redirect_valid  in  1  flush and redirect, from EX.
- redirect_pc  in  32  redirect target.
- id_ready  in  1  decode accepts id_instr this cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instr  out  32  instruction to decode; NOP (32'h0000_0013) when invalid.
- id_pc  out  32  PC of id_instr.
- id_fault  out  1  instruction-address-misaligned flag (see Configuration).

## Operation

- State machine:
  - S_REQ: may issue.
  - S_WAIT: one request outstanding.
  - S_KILL: outstanding response to be dropped.
  - S_HALT: only with the macro defined.
- imem_req = (state==S_REQ) && !redirect_valid && (!id_valid || id_ready).
  - This keeps at most one request outstanding.
  - The IF/ID register is guaranteed empty when the response returns.
- S_REQ with imem_req=1 -> S_WAIT. The issued pc is kept as req_pc.
- S_WAIT with imem_rvalid=1: id_valid<=1, id_instr<=imem_rdata, id_pc<=req_pc, pc<=pc+4 (mod 2^32 wrap), -> S_REQ.
- Handshake: when id_valid && id_ready, the entry is consumed (id_valid<=0, id_instr<=NOP) unless a response loads it in the same cycle.
- With id_valid=1 and id_ready=0, id_instr and id_pc are held stable.
- redirect_valid has the highest priority, in every state:
  - id_valid<=0, id_instr<=NOP, pc<={redirect_pc[31:2],2'b00}.
  - S_WAIT without rvalid -> S_KILL.
  - S_WAIT with rvalid in the same cycle -> response dropped, S_REQ.
  - S_KILL stays in S_KILL.
  - S_REQ stays in S_REQ; no request that cycle.
- S_KILL with imem_rvalid=1 -> data dropped, -> S_REQ. A redirect in the same cycle updates pc.
- Reset values:
  - pc=RESET_PC, state=S_REQ.
  - id_valid=0, id_instr=NOP, id_pc=RESET_PC, id_fault=0.
  - imem_req=0 while rst=1.
- Reset asserted mid-operation abandons any outstanding request. Memory must drop it on rst as well.

## Timing

- Request in cycle n, response in n+k (k≥1), id_valid=1 in n+k+1.
- Next request is issued in n+k+1 if the register can accept.
- Best-case throughput is one instruction per 2 cycles (k=1).
- Redirect in cycle n: id_valid=0 in n+1. The first request to the target is no earlier than n+1, or the response edge of an in-flight fetch if later.
- imem_addr is registered pc; no combinational path from imem_rdata to imem_req.

## Configuration

- IFETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets id_valid=1, id_fault=1, id_instr=NOP, id_pc=redirect_pc, then -> S_HALT (no requests; any in-flight response is discarded).
  - S_HALT is left only by the next redirect.
- Undefined: redirect_pc[1:0] is ignored (forced 00), id_fault is tied 0, and S_HALT does not exist.

## Structure

- Shared package riscv_pkg:
  - XLEN.
  - NOP_INSTR (32'h0000_0013).
  - RESET_PC default.
  - Fetch state enum.
- One natural sub-module, if_id_reg: the valid/instr/pc/fault holding register with load, consume and flush inputs.
- PC logic and the FSM stay in ifetch.

## Test plan

- Reset release, RESET_PC=0, memory k=1 returning addr+0x100 -> requests at 0x0, 0x4, 0x8 every 2 cycles; id_instr=0x100, 0x104, 0x108 with matching id_pc.
- id_ready=0 for 5 cycles with id_valid=1 -> id_instr/id_pc stable, imem_req=0; the next request issues in the cycle id_ready rises.
- redirect to 0x200 while S_WAIT, k=3 -> the old response is dropped, id_valid stays 0, the next imem_addr is 0x200.
- redirect to 0x40 in the same cycle as imem_rvalid -> the response is not loaded and the next request goes to 0x40.
- pc=0xFFFF_FFFC, sequential fetch -> the next imem_addr is 0x0000_0000.
- Macro defined, redirect to 0x102 -> id_fault=1, id_pc=0x102, no imem_req until a redirect to 0x300, after which fetch resumes at 0x300.
